uart_cmd_decoder: RTL
=====================

Name: uart_cmd_decoder

Overview:
- Consumes the byte stream from the UART receiver (data_ready strobe, data byte, end-of-packet strobe).
- Assembles fixed 5-byte command frames: SYNC, ADDR, DATA_HI, DATA_LO, CSUM.
- Validates each frame and presents it as a valid/ready register-write command to the oscilloscope configuration block (trigger level, timebase, channel setup).
- Reports framing, checksum, timeout and overflow errors, and keeps good/error frame counters.

Parameters:
- sync_byte, 8'hA5, frame start marker.
- max_addr, 8'd32, number of legal addresses; a frame with ADDR >= max_addr is rejected.

Ports:
- clk  in  1  system clock (same domain as the UART receiver).
- rst  in  1  synchronous, active-high reset.
- rx_data_ready  in  1  one-cycle strobe: rx_data is valid.
- rx_data  in  8  received byte.
- rx_endofpacket  in  1  one-cycle strobe: line-idle gap detected after a burst.
- cmd_valid  out  1  command available; held until accepted.
- cmd_ready  in  1  consumer accepts the command when cmd_valid and cmd_ready are both high.
- cmd_addr  out  8  register address.
- cmd_data  out  16  register data, {DATA_HI, DATA_LO}.
- err_pulse  out  1  one-cycle error strobe.
- err_code  out  2  code for the last error: 1 = checksum, 2 = timeout, 3 = overflow or bad address. Holds its value until the next error.
- good_count  out  16  frames delivered, wrapping counter.
- err_count  out  8  errors flagged, saturates at 255.

Behaviour:
- Reset (synchronous, active-high): state = S_IDLE; cmd_valid = 0; cmd_addr = 0; cmd_data = 0; err_pulse = 0; err_code = 0; good_count = 0; err_count = 0. Reset overrides any pending command or partial frame.
- FSM states: S_IDLE, S_ADDR, S_DHI, S_DLO, S_CSUM. All transitions below are qualified by rx_data_ready.
- S_IDLE:
  - Byte == sync_byte -> S_ADDR, running checksum cleared to 0.
  - Any other byte is silently discarded: no error, no counter change.
- S_ADDR, S_DHI, S_DLO: capture the byte into a shadow register, XOR it into the checksum, advance to the next state.
- S_CSUM: compare the byte with the checksum (ADDR ^ DATA_HI ^ DATA_LO), then return to S_IDLE.
  - Match, ADDR < max_addr, cmd_valid low -> load cmd_addr/cmd_data from the shadow registers; cmd_valid = 1 on the next cycle; good_count += 1.
  - Mismatch -> err code 1; frame dropped.
  - ADDR >= max_addr, or cmd_valid still high (not yet accepted) -> err code 3; new frame dropped, pending command untouched.
  - If a frame has both a checksum mismatch and a bad address, code 1 wins.
- Latency: cmd_valid rises exactly 1 cycle after the rx_data_ready cycle of the CSUM byte.
- Handshake:
  - cmd_valid falls the cycle after cmd_valid && cmd_ready.
  - cmd_addr/cmd_data stay stable while cmd_valid is high.
  - cmd_ready while cmd_valid is low has no effect.
  - Acceptance and a new frame completing in the same cycle: the acceptance takes effect first, so the new frame is loaded (no overflow) and cmd_valid stays high.
- Timeout: rx_endofpacket in any state other than S_IDLE -> S_IDLE, err code 2. rx_endofpacket in S_IDLE is ignored.
- rx_data_ready and rx_endofpacket in the same cycle: the byte is processed and the timeout is ignored.
- Error signalling: err_pulse is high for the cycle after the error is detected; err_code updates in that same cycle; err_count increments in that same cycle unless it is already 255.
- SYNC inside a frame: a sync_byte value received in S_ADDR..S_CSUM is treated as ordinary data. There is no resync mid-frame; the next resync happens via the checksum error or a timeout.
- good_count wraps from 65535 to 0.

Decomposition:
- Package uart_cmd_pkg holds:
  - state enum (S_IDLE..S_CSUM);
  - error code constants ERR_NONE=0, ERR_CSUM=1, ERR_TIMEOUT=2, ERR_OVF=3;
  - frame length constant FRAME_LEN=5.
- No sub-module. FSM, checksum, output register and counters live in one module, roughly 150-250 lines.

Test Plan:
- Good frame: bytes A5 03 12 34 25, cmd_ready = 1 -> one cycle after the CSUM strobe, cmd_valid = 1, cmd_addr = 03, cmd_data = 1234; good_count = 1; no err_pulse.
- Bad checksum: bytes A5 03 12 34 26 -> no cmd_valid; err_pulse for 1 cycle; err_code = 1; err_count = 1. A following good frame is decoded correctly.
- Timeout: bytes A5 03 12, then an rx_endofpacket strobe -> err_code = 2; state returns to idle. Next, bytes A5 05 00 FF FA -> cmd_addr = 05, cmd_data = 00FF.
- Backpressure: cmd_ready = 0; frame A5 01 00 01 00 followed by frame A5 02 00 02 00 -> first command held stable; second frame gives err_code = 3. Raise cmd_ready -> cmd_valid drops the next cycle; good_count = 1.
- Bad address and noise: bytes 00 FF then A5 20 00 00 20 (max_addr = 32) -> leading junk ignored; err_code = 3; no cmd_valid.
- Reset mid-frame: bytes A5 03 12, assert rst for 1 cycle, then A5 03 12 34 25 -> outputs and counters return to their reset values; good_count = 1 after the second frame.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command frame decoder.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DHI,
    S_DLO,
    S_CSUM
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVF     = 2'd3;

  localparam int FRAME_LEN = 5;

endpackage

// File: rtl/uart_cmd_decoder.sv
// Assembles SYNC/ADDR/DATA_HI/DATA_LO/CSUM frames from the UART byte stream
// and presents them as valid/ready register-write commands.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] sync_byte = 8'hA5,
  parameter logic [7:0] max_addr  = 8'd32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_data_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_endofpacket,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_addr,
  output logic [15:0] cmd_data,
  output logic        err_pulse,
  output logic [1:0]  err_code,
  output logic [15:0] good_count,
  output logic [7:0]  err_count
);

  state_t     state;
  logic [7:0] csum;
  logic [7:0] addr_sh;
  logic [7:0] dhi_sh;
  logic [7:0] dlo_sh;

  logic       accept;
  logic       err_det;
  logic [1:0] err_kind;
  logic       load;

  assign accept = cmd_valid && cmd_ready;

  // An accept in the same cycle frees the output register, so it is not an overflow.
  always_comb begin
    err_det  = 1'b0;
    err_kind = ERR_NONE;
    load     = 1'b0;
    if (rx_data_ready) begin
      if (state == S_CSUM) begin
        if (rx_data != csum) begin
          err_det  = 1'b1;
          err_kind = ERR_CSUM;
        end else if ((addr_sh >= max_addr) || (cmd_valid && !accept)) begin
          err_det  = 1'b1;
          err_kind = ERR_OVF;
        end else begin
          load = 1'b1;
        end
      end
    end else if (rx_endofpacket && (state != S_IDLE)) begin
      err_det  = 1'b1;
      err_kind = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      csum       <= 8'h00;
      addr_sh    <= 8'h00;
      dhi_sh     <= 8'h00;
      dlo_sh     <= 8'h00;
      cmd_valid  <= 1'b0;
      cmd_addr   <= 8'h00;
      cmd_data   <= 16'h0000;
      err_pulse  <= 1'b0;
      err_code   <= ERR_NONE;
      good_count <= 16'h0000;
      err_count  <= 8'h00;
    end else begin
      err_pulse <= err_det;
      if (err_det) begin
        err_code <= err_kind;
        if (err_count != 8'hFF) begin
          err_count <= err_count + 8'd1;
        end
      end

      if (load) begin
        cmd_valid  <= 1'b1;
        cmd_addr   <= addr_sh;
        cmd_data   <= {dhi_sh, dlo_sh};
        good_count <= good_count + 16'd1;
      end else if (accept) begin
        cmd_valid <= 1'b0;
      end

      // A sync value mid-frame is plain data; only a bad checksum or timeout resyncs.
      if (rx_data_ready) begin
        case (state)
          S_IDLE: begin
            if (rx_data == sync_byte) begin
              state <= S_ADDR;
              csum  <= 8'h00;
            end
          end
          S_ADDR: begin
            addr_sh <= rx_data;
            csum    <= csum ^ rx_data;
            state   <= S_DHI;
          end
          S_DHI: begin
            dhi_sh <= rx_data;
            csum   <= csum ^ rx_data;
            state  <= S_DLO;
          end
          S_DLO: begin
            dlo_sh <= rx_data;
            csum   <= csum ^ rx_data;
            state  <= S_CSUM;
          end
          S_CSUM: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end else if (rx_endofpacket) begin
        state <= S_IDLE;
      end
    end
  end

endmodule
